// File: rtl/chebyshev_batch_sched.sv
// chebyshev_batch_sched: issues a batch of indexed calls to a chebyshev unit,
// limits outstanding work to the result FIFO size (credits), and streams the
// returned values out in return order with a last marker on the final result.
// Optional feature macro: CHEB_SCHED_SUM_EN adds batch_sum[47:0], the wrapped
// unsigned sum of every return value of the batch.
module chebyshev_batch_sched #(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [31:0] IDX_STRIDE = 32'd1
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        go,
   input  logic [31:0] base_idx,
   input  logic [15:0] count,
   output logic        sched_busy,
   output logic        batch_done,
   output logic        cheb_start,
   input  logic        cheb_busy,
   output logic [31:0] cheb_idx,
   input  logic        cheb_done,
   output logic        cheb_stall,
   input  logic [31:0] cheb_returndata,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_data,
   output logic        res_last
`ifdef CHEB_SCHED_SUM_EN
   ,
   output logic [47:0] batch_sum
`endif
);
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
   state_t state_q, state_d;

   logic [31:0]   idx_q, idx_d;
   logic [15:0]   remain_q, remain_d, count_q, count_d, popcnt_q, popcnt_d;
   logic [CW-1:0] infl_q, infl_d, occ_q, occ_d;
   logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
   logic [31:0]   mem_q [FIFO_DEPTH];
   logic          active, fifo_full, credit_ok, call_acc, ret_acc, push, pop;

   // returns only count while a batch is live; stray ones in IDLE are dropped
   assign active    = (state_q == ISSUE) || (state_q == DRAIN);
   assign fifo_full = (occ_q == DEPTH_C);
   // every outstanding call owns a FIFO slot, so a return can never be refused for long
   assign credit_ok = ({1'b0, infl_q} + {1'b0, occ_q}) < {1'b0, DEPTH_C};
   assign call_acc  = cheb_start && !cheb_busy;
   assign ret_acc   = cheb_done && !cheb_stall;
   assign push      = ret_acc && active && (infl_q != '0);
   assign pop       = res_valid && res_ready;

   assign cheb_stall = fifo_full;
   assign cheb_idx   = idx_q;
   assign res_valid  = active && (occ_q != '0);
   assign res_data   = res_valid ? mem_q[rptr_q] : '0;
   assign res_last   = res_valid && (popcnt_q == count_q - 16'd1);

   // state register
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:  if (go) state_d = (count == 16'd0) ? FIN : ISSUE;
         ISSUE: if (call_acc && remain_q == 16'd1) state_d = DRAIN;
         DRAIN: if (infl_q == '0 && occ_q == '0 && popcnt_q == count_q) state_d = FIN;
         FIN:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs; start is withheld while no credit is free
   always_comb begin
      sched_busy = (state_q != IDLE);
      batch_done = (state_q == FIN);
      cheb_start = (state_q == ISSUE) && credit_ok;
   end

   // datapath next state: batch latch, call index, credits, FIFO pointers
   always_comb begin
      idx_d    = idx_q;
      remain_d = remain_q;
      count_d  = count_q;
      popcnt_d = popcnt_q;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      infl_d   = infl_q + CW'(call_acc) - CW'(push);
      occ_d    = occ_q + CW'(push) - CW'(pop);
      if (state_q == IDLE && go) begin
         idx_d    = base_idx;
         remain_d = count;
         count_d  = count;
         popcnt_d = '0;
      end
      if (call_acc) begin
         idx_d    = idx_q + IDX_STRIDE;
         remain_d = remain_q - 16'd1;
      end
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop) begin
         rptr_d   = rptr_q + AW'(1);
         popcnt_d = popcnt_q + 16'd1;
      end
   end

   // datapath registers and FIFO storage
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         idx_q    <= '0;
         remain_q <= '0;
         count_q  <= '0;
         popcnt_q <= '0;
         infl_q   <= '0;
         occ_q    <= '0;
         wptr_q   <= '0;
         rptr_q   <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else begin
         idx_q    <= idx_d;
         remain_q <= remain_d;
         count_q  <= count_d;
         popcnt_q <= popcnt_d;
         infl_q   <= infl_d;
         occ_q    <= occ_d;
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         if (push) mem_q[wptr_q] <= cheb_returndata;
      end
   end

`ifdef CHEB_SCHED_SUM_EN
   logic [47:0] sum_q, sum_d;

   assign batch_sum = sum_q;

   // running sum of accepted returns, restarted when a batch is launched
   always_comb begin
      sum_d = sum_q;
      if (state_q == IDLE && go) sum_d = '0;
      if (push) sum_d = sum_q + {16'd0, cheb_returndata};
   end

   // sum register, held after the batch until the next launch
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) sum_q <= '0;
      else         sum_q <= sum_d;
   end
`endif

endmodule

// File: tb/tb_chebyshev_batch_sched.sv
// Bench for chebyshev_batch_sched: random call/return/ready traffic checked
// against a queue-based model of the batch (issued / returned / popped).
module tb_chebyshev_batch_sched;
   localparam int          DEPTH  = 4;
   localparam logic [31:0] STRIDE = 32'd1;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        go = 1'b0;
   logic [31:0] base_idx = '0;
   logic [15:0] count = '0;
   logic        cheb_busy = 1'b0;
   logic        cheb_done = 1'b0;
   logic [31:0] cheb_returndata = '0;
   logic        res_ready = 1'b0;
   logic        sched_busy, batch_done, cheb_start, cheb_stall;
   logic        res_valid, res_last;
   logic [31:0] cheb_idx, res_data;
`ifdef CHEB_SCHED_SUM_EN
   logic [47:0] batch_sum;
`endif

   int n_chk = 0;
   int n_fail = 0;

   chebyshev_batch_sched #(.FIFO_DEPTH(DEPTH), .IDX_STRIDE(STRIDE)) dut (
      .clock(clock), .resetn(resetn), .go(go), .base_idx(base_idx), .count(count),
      .sched_busy(sched_busy), .batch_done(batch_done), .cheb_start(cheb_start),
      .cheb_busy(cheb_busy), .cheb_idx(cheb_idx), .cheb_done(cheb_done),
      .cheb_stall(cheb_stall), .cheb_returndata(cheb_returndata),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_last(res_last)
`ifdef CHEB_SCHED_SUM_EN
      , .batch_sum(batch_sum)
`endif
   );

   always #5 clock = ~clock;

   // one batch with random traffic; the model tracks calls awaiting return,
   // returned values awaiting pop, and counts of issued / popped results
   task automatic run_batch(input logic [31:0] base, input int cnt, input int busy_pct,
                            input int done_pct, input int ready_pct, input int ready_hold,
                            input int busy_hold, input bit ones, input string tag);
      logic [31:0] ret_q[$];
      logic [31:0] exp_q[$];
      int          issued, popped, cyc, since, busy_left;
      logic [47:0] sum;
      bit          fin, st, rv, rl, bd, cacc, racc, pacc, exp_st;
      logic [31:0] ix, rd, exp_ix;
      issued = 0; popped = 0; cyc = 0; since = -1; busy_left = busy_hold;
      sum = '0; fin = 1'b0;
      @(negedge clock);
      go = 1'b1; base_idx = base; count = cnt[15:0];
      cheb_busy = 1'b0; cheb_done = 1'b0; res_ready = 1'b0;
      @(negedge clock);
      go = 1'b0;
      n_chk++;
      if (cheb_start !== 1'b1) begin
         n_fail++; $display("FAIL %s first_start_latency: got %b want 1", tag, cheb_start);
      end
      while (!fin && cyc < 3000) begin
         st = cheb_start; ix = cheb_idx; rv = res_valid; rd = res_data; rl = res_last; bd = batch_done;
         exp_st = (issued < cnt) && ((issued - popped) < DEPTH);
         n_chk++;
         if (st !== exp_st) begin
            n_fail++; $display("FAIL %s start_credit cyc%0d: got %b want %b", tag, cyc, st, exp_st);
         end
         if (st) begin
            exp_ix = base + STRIDE * 32'(issued);
            n_chk++;
            if (ix !== exp_ix) begin
               n_fail++; $display("FAIL %s cheb_idx: got %h want %h", tag, ix, exp_ix);
            end
         end
         n_chk++;
         if (rv !== (exp_q.size() != 0)) begin
            n_fail++; $display("FAIL %s res_valid cyc%0d: got %b want %b", tag, cyc, rv, exp_q.size() != 0);
         end
         n_chk++;
         if (cheb_stall !== (exp_q.size() == DEPTH)) begin
            n_fail++; $display("FAIL %s cheb_stall: got %b want %b", tag, cheb_stall, exp_q.size() == DEPTH);
         end
         if (rv && exp_q.size() != 0) begin
            n_chk++;
            if (rd !== exp_q[0]) begin
               n_fail++; $display("FAIL %s res_data #%0d: got %h want %h", tag, popped, rd, exp_q[0]);
            end
            n_chk++;
            if (rl !== (popped == cnt - 1)) begin
               n_fail++; $display("FAIL %s res_last #%0d: got %b want %b", tag, popped, rl, popped == cnt - 1);
            end
         end
         n_chk++;
         if (bd !== (since == 1)) begin
            n_fail++; $display("FAIL %s batch_done cyc%0d: got %b want %b", tag, cyc, bd, since == 1);
         end
         n_chk++;
         if (sched_busy !== 1'b1) begin
            n_fail++; $display("FAIL %s sched_busy: got %b want 1", tag, sched_busy);
         end
         if (ready_hold > 0 && cyc == ready_hold) begin
            n_chk++;
            if (issued != ((cnt < DEPTH) ? cnt : DEPTH)) begin
               n_fail++; $display("FAIL %s held_ready_issued: got %0d want %0d", tag, issued,
                                  (cnt < DEPTH) ? cnt : DEPTH);
            end
         end
         if (bd) begin
            fin = 1'b1;
`ifdef CHEB_SCHED_SUM_EN
            n_chk++;
            if (batch_sum !== sum) begin
               n_fail++; $display("FAIL %s batch_sum: got %h want %h", tag, batch_sum, sum);
            end
`endif
         end
         // stray go requests during the batch must be ignored
         go = !bd && ($urandom_range(0, 9) == 0);
         base_idx = $urandom; count = 16'($urandom);
         if (busy_left > 0 && st) begin
            cheb_busy = 1'b1; busy_left--;
         end else cheb_busy = ($urandom_range(0, 99) < busy_pct);
         res_ready = (cyc < ready_hold) ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
         if (ret_q.size() != 0 && $urandom_range(0, 99) < done_pct) begin
            cheb_done = 1'b1; cheb_returndata = ret_q[0];
         end else begin
            cheb_done = 1'b0; cheb_returndata = $urandom;
         end
         cacc = st && !cheb_busy;
         racc = cheb_done && !cheb_stall;
         pacc = rv && res_ready;
         if (pacc) begin
            void'(exp_q.pop_front()); popped++;
         end
         if (racc) begin
            sum = sum + {16'd0, ret_q[0]};
            exp_q.push_back(ret_q.pop_front());
         end
         if (cacc) begin
            ret_q.push_back(ones ? 32'hFFFF_FFFF : $urandom);
            issued++;
         end
         if (since >= 0) since++;
         if (popped == cnt && since < 0) since = 0;
         @(negedge clock);
         cyc++;
      end
      go = 1'b0; cheb_done = 1'b0; cheb_busy = 1'b0; res_ready = 1'b0;
      n_chk++;
      if (!fin) begin
         n_fail++; $display("FAIL %s timeout: got issued=%0d popped=%0d want %0d", tag, issued, popped, cnt);
      end
      n_chk++;
      if (sched_busy !== 1'b0 || batch_done !== 1'b0) begin
         n_fail++; $display("FAIL %s back_to_idle: got busy=%b done=%b want 0 0", tag, sched_busy, batch_done);
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clock);
      n_chk++;
      if ({sched_busy, batch_done, cheb_start, cheb_idx, cheb_stall, res_valid, res_data, res_last} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got busy=%b done=%b start=%b idx=%h stall=%b rv=%b rd=%h rl=%b want all 0",
                  sched_busy, batch_done, cheb_start, cheb_idx, cheb_stall, res_valid, res_data, res_last);
      end
      resetn = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_basic();
      run_batch(32'd10, 3, 0, 100, 100, 0, 0, 1'b0, "basic");
   endtask

   task automatic test_zero_count();
      @(negedge clock);
      go = 1'b1; count = 16'd0; base_idx = $urandom;
      @(negedge clock);
      go = 1'b0;
      n_chk++;
      if ({sched_busy, batch_done, cheb_start} !== 3'b110) begin
         n_fail++; $display("FAIL zero_count_fin: got busy,done,start=%b want 110", {sched_busy, batch_done, cheb_start});
      end
      @(negedge clock);
      n_chk++;
      if ({sched_busy, batch_done, cheb_start} !== 3'b000) begin
         n_fail++; $display("FAIL zero_count_idle: got busy,done,start=%b want 000", {sched_busy, batch_done, cheb_start});
      end
   endtask

   task automatic test_backpressure();
      run_batch($urandom, 8, 0, 100, 100, 30, 0, 1'b0, "backpressure");
   endtask

   task automatic test_busy_stall();
      run_batch(32'h4000, 4, 0, 100, 100, 0, 5, 1'b0, "busy_stall");
   endtask

   task automatic test_random();
      run_batch(32'hFFFF_FFFE, 5, 30, 60, 60, 0, 0, 1'b0, "wrap");
      for (int k = 0; k < 6; k++)
         run_batch($urandom, $urandom_range(1, 12), $urandom_range(0, 60),
                   $urandom_range(20, 100), $urandom_range(20, 100), 0, 0, 1'b0, "random");
   endtask

   task automatic test_mid_reset();
      int issued, pending, returned, cyc;
      issued = 0; pending = 0; returned = 0; cyc = 0;
      @(negedge clock);
      go = 1'b1; base_idx = 32'h77; count = 16'd6; cheb_busy = 1'b0; res_ready = 1'b1;
      @(negedge clock);
      go = 1'b0;
      while (issued < 6 && cyc < 200) begin
         cheb_done = (pending > 0) && (returned < 3);
         cheb_returndata = $urandom;
         if (cheb_done && !cheb_stall) begin pending--; returned++; end
         if (cheb_start) begin issued++; pending++; end
         @(negedge clock);
         cyc++;
      end
      cheb_done = 1'b0;
      @(negedge clock);
      n_chk++;
      if (sched_busy !== 1'b1 || cheb_start !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_drain: got busy=%b start=%b want 1 0", sched_busy, cheb_start);
      end
      resetn = 1'b0;
      #1;
      n_chk++;
      if ({sched_busy, batch_done, cheb_start, cheb_idx, cheb_stall, res_valid, res_data, res_last} !== '0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got busy=%b start=%b idx=%h rv=%b rd=%h want all 0",
                            sched_busy, cheb_start, cheb_idx, res_valid, res_data);
      end
      @(negedge clock);
      resetn = 1'b1;
      // late returns for the abandoned batch are swallowed in IDLE
      for (int k = 0; k < 2; k++) begin
         cheb_done = 1'b1; cheb_returndata = $urandom;
         @(negedge clock);
         n_chk++;
         if ({sched_busy, res_valid, cheb_stall} !== 3'b000) begin
            n_fail++; $display("FAIL stray_return: got busy,rv,stall=%b want 000", {sched_busy, res_valid, cheb_stall});
         end
      end
      cheb_done = 1'b0;
      run_batch($urandom, 2, 20, 70, 70, 0, 0, 1'b0, "after_reset");
   endtask

`ifdef CHEB_SCHED_SUM_EN
   task automatic test_sum();
      run_batch(32'h100, 3, 0, 100, 100, 0, 0, 1'b1, "sum");
      n_chk++;
      if (batch_sum !== 48'h0002_FFFF_FFFD) begin
         n_fail++; $display("FAIL sum_held: got %h want 0002fffffffd", batch_sum);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_zero_count();
      test_backpressure();
      test_busy_stall();
      test_random();
      test_mid_reset();
`ifdef CHEB_SCHED_SUM_EN
      test_sum();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
